// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode, EX-stage, memory-handshake inputs and pipeline-control outputs of hazard_ctrl
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_memtoreg;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             load_used;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_hold;
  logic             ex_mem_hold;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memtoreg, ex_rt, branch_taken, mem_req, mem_ready,
    input  load_used, pc_write, if_id_write, if_id_flush, id_ex_hold, ex_mem_hold, mem_err,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memtoreg, ex_rt, branch_taken, mem_req, mem_ready,
    output load_used, pc_write, if_id_write, if_id_flush, id_ex_hold, ex_mem_hold, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubble, branch flush and memory-wait freeze control for the pipeline registers.
// Define HAZARD_STATS_EN to add saturating stall/flush statistics counters.
module hazard_ctrl #(
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT         = 15,
  parameter int CNT_W               = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int FW = $clog2(BRANCH_FLUSH_CYCLES + 1);
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, FLUSH} state_t;
  state_t        r_state, w_next;
  logic [WW-1:0] r_wait, w_wait_d, w_wcnt;
  logic [FW-1:0] r_fl, w_fl_d;
  logic          r_err, w_err_set, w_br_acc;
  logic          w_detect, w_busy;
  logic          w_lu, w_pcw, w_ifw, w_fl, w_hold;
  assign w_detect = bus.ex_memtoreg && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
  assign w_busy   = bus.mem_req && !bus.mem_ready;
  // stalled-cycle number this cycle would be; the RUN cycle that enters the wait is the first
  assign w_wcnt   = (r_state == MEM_WAIT) ? r_wait + 1'b1 : WW'(1);
  always_comb begin
    w_next    = r_state;
    w_wait_d  = r_wait;
    w_fl_d    = r_fl;
    w_err_set = 1'b0;
    w_br_acc  = 1'b0;
    w_lu      = 1'b0;
    w_pcw     = 1'b1;
    w_ifw     = 1'b1;
    w_fl      = 1'b0;
    w_hold    = 1'b0;
    case (r_state)
      RUN, LOAD_STALL: begin
        w_next = RUN;
        if (bus.branch_taken) begin
          w_fl     = 1'b1;
          w_lu     = 1'b1;
          w_br_acc = 1'b1;
          w_fl_d   = FW'(BRANCH_FLUSH_CYCLES - 1);
          w_next   = (BRANCH_FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (w_busy) begin
          w_pcw     = 1'b0;
          w_ifw     = 1'b0;
          w_hold    = 1'b1;
          w_err_set = (w_wcnt == WW'(MEM_TIMEOUT));
          w_wait_d  = w_wcnt;
          w_next    = w_err_set ? RUN : MEM_WAIT;
        end else if (w_detect && r_state == RUN) begin
          w_lu   = 1'b1;
          w_pcw  = 1'b0;
          w_ifw  = 1'b0;
          w_next = LOAD_STALL;
        end
      end
      MEM_WAIT: begin
        w_next = RUN;
        if (!bus.mem_ready) begin
          w_pcw     = 1'b0;
          w_ifw     = 1'b0;
          w_hold    = 1'b1;
          w_err_set = (w_wcnt == WW'(MEM_TIMEOUT));
          w_wait_d  = w_wcnt;
          w_next    = w_err_set ? RUN : MEM_WAIT;
        end
      end
      FLUSH: begin
        w_fl     = 1'b1;
        w_br_acc = bus.branch_taken;
        w_fl_d   = bus.branch_taken ? FW'(BRANCH_FLUSH_CYCLES - 1) : r_fl - 1'b1;
        w_next   = (!bus.branch_taken && r_fl == FW'(1)) ? RUN : FLUSH;
      end
    endcase
  end
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_fl    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_d;
      r_fl    <= w_fl_d;
      r_err   <= r_err | w_err_set;
    end
  end
  // reset forces a frozen, flushed front end regardless of state
  assign bus.load_used   = rst_n & w_lu;
  assign bus.pc_write    = rst_n & w_pcw;
  assign bus.if_id_write = rst_n & w_ifw;
  assign bus.if_id_flush = !rst_n | w_fl;
  assign bus.id_ex_hold  = rst_n & w_hold;
  assign bus.ex_mem_hold = rst_n & w_hold;
  assign bus.mem_err     = r_err;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall, r_flush;
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (!w_pcw && !(&r_stall)) r_stall <= r_stall + 1'b1;
      if (w_br_acc && !(&r_flush)) r_flush <= r_flush + 1'b1;
    end
  end
  assign bus.stall_cnt = r_stall;
  assign bus.flush_cnt = r_flush;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven checks of hazard_ctrl outputs through a scoreboard queue, plus timeout and reset sequences.
module tb_hazard_ctrl;
  localparam logic [6:0] IDLE = 7'b0110000;
  localparam logic [6:0] BUB  = 7'b1000000;
  localparam logic [6:0] HOLD = 7'b0000110;
  localparam logic [6:0] BR   = 7'b1111000;
  localparam logic [6:0] FLS  = 7'b0111000;
  localparam logic [6:0] RST  = 7'b0001000;
  localparam logic [6:0] ERR  = 7'b0000001;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       m2r;
    logic [4:0] xrt;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;
  typedef struct {
    int         id;
    logic [6:0] exp;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_vec = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  vec_t tbl[$];
  sb_t  sbq[$];
  hazard_ctrl_if #(.CNT_W(16)) bus ();
  hazard_ctrl #(.BRANCH_FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                              input logic m2r, input logic [4:0] xrt, input logic br,
                              input logic req, input logic rdy, input logic [6:0] exp);
    vec_t v;
    v = '{rs: rs, rt: rt, uses: uses, m2r: m2r, xrt: xrt, br: br, req: req, rdy: rdy, exp: exp};
    return v;
  endfunction
  function automatic logic [6:0] dut_out();
    return {bus.load_used, bus.pc_write, bus.if_id_write, bus.if_id_flush,
            bus.id_ex_hold, bus.ex_mem_hold, bus.mem_err};
  endfunction
  task automatic check_out(input string nm, input logic [6:0] exp);
    n_cmp++;
    if (dut_out() !== exp) begin
      n_fail++;
      $display("FAIL %s: {lu,pcw,ifw,fl,idh,exh,err} got %b want %b", nm, dut_out(), exp);
    end
  endtask
  task automatic check_cnt(input string nm);
    logic [15:0] es, ef;
`ifdef HAZARD_STATS_EN
    es = 16'(exp_stall);
    ef = 16'(exp_flush);
`else
    es = 16'd0;
    ef = 16'd0;
`endif
    n_cmp++;
    if (bus.stall_cnt !== es || bus.flush_cnt !== ef) begin
      n_fail++;
      $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d want %0d %0d", nm, bus.stall_cnt, bus.flush_cnt, es, ef);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.id_uses_rt   = v.uses;
    bus.ex_memtoreg  = v.m2r;
    bus.ex_rt        = v.xrt;
    bus.branch_taken = v.br;
    bus.mem_req      = v.req;
    bus.mem_ready    = v.rdy;
  endtask
  // drive at posedge, compare 2 time units later, state advances on the following negedge
  task automatic apply(input vec_t v);
    sb_t s;
    @(posedge clk);
    drive(v);
    sbq.push_back('{id: n_vec, exp: v.exp});
    n_vec++;
    if (!v.exp[5]) exp_stall++;
    if (v.br && v.exp[3]) exp_flush++;
    #2;
    s = sbq.pop_front();
    check_out($sformatf("vec%0d", s.id), s.exp);
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    #3;
    check_out("reset_outputs", RST);
    check_cnt("reset_counters");
    bus.branch_taken = 1'b1;
    bus.mem_req      = 1'b1;
    #1;
    check_out("reset_ignores_inputs", RST);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, BUB));
    tbl.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(1, 9, 0, 1, 9, 0, 0, 0, IDLE));
    tbl.push_back(mk(1, 9, 1, 1, 9, 0, 0, 0, BUB));
    tbl.push_back(mk(1, 9, 1, 1, 9, 0, 0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(8, 0, 0, 1, 8, 1, 0, 0, BR));
    tbl.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, FLS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, FLS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, FLS));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD));
    tbl.push_back(mk(5, 0, 0, 1, 5, 0, 1, 0, HOLD));
    tbl.push_back(mk(5, 0, 0, 1, 5, 0, 1, 1, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk(5, 0, 0, 1, 5, 0, 1, 0, HOLD));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, IDLE));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    #1;
    check_cnt("table_counters");
    for (int i = 0; i < 15; i++) apply(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE | ERR));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE | ERR));
    apply(mk(8, 0, 0, 1, 8, 0, 0, 0, BUB | ERR));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE | ERR));
    #1;
    check_cnt("timeout_counters");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD | ERR));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, HOLD | ERR));
    #1;
    rst_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    check_out("midstall_reset", RST);
    check_cnt("midstall_reset_counters");
    @(posedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    apply(mk(8, 0, 0, 1, 8, 1, 0, 0, BR));
    apply(mk(8, 0, 0, 1, 8, 0, 0, 0, FLS));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, IDLE));
    #1;
    check_cnt("branch_detect_counters");
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
